// File: rtl/mips32_dmem_responder.sv
// mips32_dmem_responder: 1024x32 data memory serving MEM-stage loads/stores over valid/ready with a programmable wait
//   clk, rst_n (sync, active-low); req_valid/req_ready/req_we/req_addr/req_wdata request channel;
//   rsp_valid/rsp_ready/rsp_rdata/rsp_err response channel; busy = not idle; ld_count/st_count wrap.
module mips32_dmem_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_rdata,
  output logic             rsp_err,
  output logic             busy,
  output logic [CNT_W-1:0] ld_count,
  output logic [CNT_W-1:0] st_count
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;
  state_t state;
  logic [3:0] cnt;
  logic we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] mem [DEPTH];
  logic in_range;
  assign in_range = addr < 32'(DEPTH);
  assign req_ready = state == IDLE;
  assign busy = state != IDLE;
  always_ff @(posedge clk)
    if (rst_n && state == ACCESS && we && in_range) mem[addr[AW-1:0]] <= wdata;
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err <= 1'b0;
      ld_count <= '0;
      st_count <= '0;
    end else
      case (state)
        IDLE:
          if (req_valid) begin
            we <= req_we;
            addr <= req_addr;
            wdata <= req_wdata;
            state <= LATENCY == 0 ? ACCESS : WAIT;
          end
        WAIT:
          if (cnt == 4'(LATENCY - 1)) begin
            cnt <= '0;
            state <= ACCESS;
          end else
            cnt <= cnt + 1'b1;
        ACCESS: begin
          rsp_rdata <= in_range && !we ? mem[addr[AW-1:0]] : '0;
          rsp_err <= !in_range;
          if (in_range && we) st_count <= st_count + 1'b1;
          if (in_range && !we) ld_count <= ld_count + 1'b1;
          state <= RESP;
        end
        default:
          if (!rsp_valid)
            rsp_valid <= 1'b1;
          else if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_err <= 1'b0;
            state <= IDLE;
          end
      endcase
endmodule
